pto_multi_axis: RTL and testbench

PTO_MULTI_AXIS -- requirements
Module: pto_multi_axis

---
 rtl/pto_pkg.sv | 25 ++
 rtl/pto_multi_axis_if.sv | 29 ++
 rtl/pto_channel.sv | 115 +++++++++++
 rtl/pto_multi_axis.sv | 62 ++++++
 tb/tb_pto_multi_axis.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pto_pkg.sv
// Shared types, defaults and small helpers for the multi-axis pulse-train output block.
package pto_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } ch_state_t;

  localparam int N_CH_DEFAULT      = 3;
  localparam int STEP_W_DEFAULT    = 32;
  localparam int PER_W_DEFAULT     = 16;
  localparam int DIR_SETUP_DEFAULT = 8;

  // Channel-select width; a single channel still needs a 1-bit select field.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pto_multi_axis_if.sv
// Command handshake bundle for pto_multi_axis: one command offered per cycle to a selected channel.
interface pto_multi_axis_if
  import pto_pkg::*;
#(
  parameter int N_CH   = N_CH_DEFAULT,
  parameter int STEP_W = STEP_W_DEFAULT,
  parameter int PER_W  = PER_W_DEFAULT
);

  localparam int CH_W = ch_width(N_CH);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [PER_W-1:0]  cmd_half_period;

  modport master (
    output cmd_valid, cmd_ch, cmd_dir, cmd_steps, cmd_half_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_dir, cmd_steps, cmd_half_period,
    output cmd_ready
  );

endinterface

// File: rtl/pto_channel.sv
// One step/dir channel: direction setup delay, then cmd_steps pulses of equal high/low time.
module pto_channel
  import pto_pkg::*;
#(
  parameter int STEP_W    = STEP_W_DEFAULT,
  parameter int PER_W     = PER_W_DEFAULT,
  parameter int DIR_SETUP = DIR_SETUP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [PER_W-1:0]  cmd_half_period,
  input  logic              abort,
  output logic              pto,
  output logic              motor_dir,
  output logic              busy,
  output logic              done
);

  // One timer serves both the setup delay and the half-period phases.
  localparam int TMR_W = max_int(PER_W, $clog2(DIR_SETUP + 1));

  ch_state_t         state;
  logic [TMR_W-1:0]  timer;
  logic [PER_W-1:0]  half_m1;
  logic [STEP_W-1:0] steps_left;
  logic              abort_pend;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      half_m1    <= '0;
      steps_left <= '0;
      abort_pend <= 1'b0;
      pto        <= 1'b0;
      motor_dir  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            motor_dir  <= cmd_dir;
            abort_pend <= 1'b0;
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state      <= ST_SETUP;
              timer      <= TMR_W'(DIR_SETUP - 1);
              steps_left <= cmd_steps;
              half_m1    <= (cmd_half_period == '0) ? '0 : cmd_half_period - PER_W'(1);
            end
          end
        end
        ST_SETUP: begin
          if (abort) begin
            state      <= ST_IDLE;
            steps_left <= '0;
            done       <= 1'b1;
          end else if (timer == '0) begin
            state <= ST_HIGH;
            pto   <= 1'b1;
            timer <= TMR_W'(half_m1);
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        // An abort seen mid-high is remembered so the pulse is never cut short.
        ST_HIGH: begin
          if (timer == '0) begin
            pto <= 1'b0;
            if (abort || abort_pend) begin
              state      <= ST_IDLE;
              steps_left <= '0;
              abort_pend <= 1'b0;
              done       <= 1'b1;
            end else begin
              state <= ST_LOW;
              timer <= TMR_W'(half_m1);
            end
          end else begin
            timer <= timer - TMR_W'(1);
            if (abort) abort_pend <= 1'b1;
          end
        end
        ST_LOW: begin
          if (abort) begin
            state      <= ST_IDLE;
            steps_left <= '0;
            done       <= 1'b1;
          end else if (timer == '0) begin
            steps_left <= steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_HIGH;
              pto   <= 1'b1;
              timer <= TMR_W'(half_m1);
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pto_multi_axis.sv
// Multi-axis pulse-train output: command demux feeding N_CH independent step/dir channels.
module pto_multi_axis
  import pto_pkg::*;
#(
  parameter int N_CH      = N_CH_DEFAULT,
  parameter int STEP_W    = STEP_W_DEFAULT,
  parameter int PER_W     = PER_W_DEFAULT,
  parameter int DIR_SETUP = DIR_SETUP_DEFAULT
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  pto_multi_axis_if.slave cmd,
  input  logic [N_CH-1:0] abort,
  output logic [N_CH-1:0] pto,
  output logic [N_CH-1:0] motor_dir,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done
);

  localparam int CH_W = ch_width(N_CH);

  logic            ready;
  logic [N_CH-1:0] start;

  // Out-of-range channel numbers match no channel, so ready stays low for them.
  always_comb begin
    ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cmd.cmd_ch == CH_W'(i)) ready = !busy[i];
    end
  end

  assign cmd.cmd_ready = ready;

  always_comb begin
    start = '0;
    for (int i = 0; i < N_CH; i++) begin
      start[i] = cmd.cmd_valid && ready && (cmd.cmd_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pto_channel #(
      .STEP_W    (STEP_W),
      .PER_W     (PER_W),
      .DIR_SETUP (DIR_SETUP)
    ) u_ch (
      .clk             (clk_clk),
      .rst             (reset_reset),
      .start           (start[g]),
      .cmd_dir         (cmd.cmd_dir),
      .cmd_steps       (cmd.cmd_steps),
      .cmd_half_period (cmd.cmd_half_period),
      .abort           (abort[g]),
      .pto             (pto[g]),
      .motor_dir       (motor_dir[g]),
      .busy            (busy[g]),
      .done            (done[g])
    );
  end

endmodule

// File: tb/tb_pto_multi_axis.sv
// Bench for pto_multi_axis: directed scenarios plus randomized traffic against an arithmetic timeline model.
`timescale 1ns/1ps
module tb_pto_multi_axis;

  localparam int N_CH      = 3;
  localparam int STEP_W    = 32;
  localparam int PER_W     = 16;
  localparam int DIR_SETUP = 8;

  logic            clk_clk = 1'b0;
  logic            reset_reset = 1'b1;
  logic [N_CH-1:0] abort = '0;
  logic [N_CH-1:0] pto, motor_dir, busy, done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  pto_multi_axis_if #(.N_CH(N_CH), .STEP_W(STEP_W), .PER_W(PER_W)) cmd ();

  pto_multi_axis #(
    .N_CH(N_CH), .STEP_W(STEP_W), .PER_W(PER_W), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .cmd         (cmd),
    .abort       (abort),
    .pto         (pto),
    .motor_dir   (motor_dir),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  // Reference model: each channel's last command as (accept cycle, steps, half, dir).
  int   m_start    [N_CH];
  int   m_steps    [N_CH];
  int   m_h        [N_CH];
  logic m_dir      [N_CH];
  logic m_prev_dir [N_CH];
  bit   m_used     [N_CH];

  function automatic int busy_len(input int steps, input int h);
    return (steps == 0) ? 0 : DIR_SETUP + 2 * h * steps;
  endfunction

  // Expected {pto, motor_dir, busy, done} for channel i in cycle c.
  function automatic logic [3:0] model_out(input int i, input int c);
    int k, bl;
    logic p, d, b, dn;
    if (!m_used[i]) return {1'b0, m_prev_dir[i], 1'b0, 1'b0};
    k  = c - m_start[i];
    bl = busy_len(m_steps[i], m_h[i]);
    d  = (k >= 1) ? m_dir[i] : m_prev_dir[i];
    b  = (k >= 1) && (k <= bl);
    dn = (k == bl + 1);
    p  = (m_steps[i] > 0) && (k > DIR_SETUP) && (k <= bl) &&
         (((k - DIR_SETUP - 1) % (2 * m_h[i])) < m_h[i]);
    return {p, d, b, dn};
  endfunction

  task automatic set_cmd(input logic v, input int ch, input logic dr,
                         input logic [STEP_W-1:0] st, input int hp);
    cmd.cmd_valid       = v;
    cmd.cmd_ch          = 2'(ch);
    cmd.cmd_dir         = dr;
    cmd.cmd_steps       = st;
    cmd.cmd_half_period = PER_W'(hp);
  endtask

  task automatic apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b0, 0, 1'b0, '0, 0);
    abort = '0;
    reset_reset = 1'b1;
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_rdy;
    @(negedge clk_clk);
    reset_reset = 1'b1;
    set_cmd(1'b0, 0, 1'b0, '0, 0);
    abort = '0;
    @(negedge clk_clk);
    tests_run++;
    if ({pto, motor_dir, busy, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got %b want 0", {pto, motor_dir, busy, done});
    end
    for (int i = 0; i <= N_CH; i++) begin
      set_cmd(1'b1, i, 1'b1, 32'd1, 1);
      #1;
      exp_rdy = (i < N_CH) ? 1'b1 : 1'b0;
      tests_run++;
      if (cmd.cmd_ready !== exp_rdy) begin
        tests_failed++;
        $display("[TB] FAIL reset_ready ch%0d got %b want %b", i, cmd.cmd_ready, exp_rdy);
      end
    end
    set_cmd(1'b0, 0, 1'b0, '0, 0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    repeat (2) @(negedge clk_clk);
    tests_run++;
    if ({pto, motor_dir, busy, done} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release got %b want 0", {pto, motor_dir, busy, done});
    end
  endtask

  task automatic test_basic();
    logic ep, eb, ed;
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 0, 1'b1, 32'd3, 2);
    #1;
    tests_run++;
    if (cmd.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_ready got %b want 1", cmd.cmd_ready);
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_clk);
      if (k == 1) set_cmd(1'b0, 0, 1'b0, '0, 0);
      ep = (k inside {9, 10, 13, 14, 17, 18});
      eb = (k <= 20);
      ed = (k == 21);
      tests_run++;
      if ({pto[0], motor_dir[0], busy[0], done[0]} !== {ep, 1'b1, eb, ed}) begin
        tests_failed++;
        $display("[TB] FAIL basic k=%0d {pto,dir,busy,done} got %b want %b",
                 k, {pto[0], motor_dir[0], busy[0], done[0]}, {ep, 1'b1, eb, ed});
      end
    end
  endtask

  task automatic test_zero_steps();
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 1, 1'b1, 32'd0, 3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_clk);
      if (k == 1) set_cmd(1'b0, 0, 1'b0, '0, 0);
      tests_run++;
      if ({pto[1], motor_dir[1], busy[1], done[1]} !== {1'b0, 1'b1, 1'b0, (k == 1)}) begin
        tests_failed++;
        $display("[TB] FAIL zero_steps k=%0d {pto,dir,busy,done} got %b want %b",
                 k, {pto[1], motor_dir[1], busy[1], done[1]}, {1'b0, 1'b1, 1'b0, (k == 1)});
      end
    end
  endtask

  task automatic test_busy_reject();
    logic [5:0] got, want;
    bit idle_seen;
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 2, 1'b1, 32'd2, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_clk);
      set_cmd(1'b0, 0, 1'b0, '0, 0);
      if (k == 3) begin
        set_cmd(1'b1, 2, 1'b0, 32'd5, 1);
        #1;
        tests_run++;
        if (cmd.cmd_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL busy_reject_ready got %b want 0", cmd.cmd_ready);
        end
      end
      if (k == 4) begin
        set_cmd(1'b1, 0, 1'b1, 32'd1, 1);
        #1;
        tests_run++;
        if (cmd.cmd_ready !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL other_ch_ready got %b want 1", cmd.cmd_ready);
        end
      end
      if (k >= 5) begin
        got  = {busy[2], motor_dir[2], done[2], busy[0], motor_dir[0], done[0]};
        want = {(k <= 12), 1'b1, (k == 13), (k <= 14), 1'b1, (k == 15)};
        tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("[TB] FAIL concurrent k=%0d {b2,d2,dn2,b0,d0,dn0} got %b want %b", k, got, want);
        end
      end
    end
    idle_seen = 0;
    for (int n = 0; n < 50 && !idle_seen; n++) begin
      @(negedge clk_clk);
      if (busy == '0) idle_seen = 1;
    end
    tests_run++;
    if (!idle_seen) begin
      tests_failed++;
      $display("[TB] FAIL busy_drain timeout busy=%b want 000", busy);
    end
  endtask

  task automatic test_abort_high();
    logic [2:0] got, want;
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 0, 1'b0, 32'd10, 4);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_clk);
      set_cmd(1'b0, 0, 1'b0, '0, 0);
      abort = '0;
      got  = {pto[0], busy[0], done[0]};
      want = {(k >= 9 && k <= 12), (k <= 12), (k == 13)};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL abort_high k=%0d {pto,busy,done} got %b want %b", k, got, want);
      end
      if (k == 10) abort[0] = 1'b1;
    end
  endtask

  task automatic test_abort_other();
    logic [2:0] got, want;
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 1, 1'b0, 32'd3, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_clk);
      set_cmd(1'b0, 0, 1'b0, '0, 0);
      abort = '0;
      got  = {pto[1], busy[1], done[1]};
      want = {1'b0, (k <= 4), (k == 5)};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL abort_setup k=%0d {pto,busy,done} got %b want %b", k, got, want);
      end
      if (k == 4) abort[1] = 1'b1;
    end
    @(negedge clk_clk);
    set_cmd(1'b1, 0, 1'b1, 32'd5, 2);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_clk);
      set_cmd(1'b0, 0, 1'b0, '0, 0);
      abort = '0;
      got  = {pto[0], busy[0], done[0]};
      want = {(k == 9 || k == 10), (k <= 11), (k == 12)};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL abort_low k=%0d {pto,busy,done} got %b want %b", k, got, want);
      end
      if (k == 11) abort[0] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_clk);
      abort[2] = (k < 3);
      tests_run++;
      if ({busy[2], done[2]} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL abort_idle k=%0d {busy,done} got %b want 00", k, {busy[2], done[2]});
      end
    end
    abort = '0;
  endtask

  task automatic test_half_zero();
    logic [2:0] got, want;
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 2, 1'b0, 32'd2, 0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk_clk);
      set_cmd(1'b0, 0, 1'b0, '0, 0);
      got  = {pto[2], busy[2], done[2]};
      want = {(k == 9 || k == 11), (k <= 12), (k == 13)};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL half_zero k=%0d {pto,busy,done} got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_max_steps();
    logic [2:0] got, want;
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 0, 1'b1, {STEP_W{1'b1}}, 0);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk_clk);
      set_cmd(1'b0, 0, 1'b0, '0, 0);
      abort = '0;
      if (k <= 40) want = {(k >= 9 && ((k - 9) % 2 == 0)), 1'b1, 1'b0};
      else         want = {1'b0, 1'b0, (k == 41)};
      got = {pto[0], busy[0], done[0]};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL max_steps k=%0d {pto,busy,done} got %b want %b", k, got, want);
      end
      if (k == 40) abort[0] = 1'b1;
    end
  endtask

  task automatic test_reset_mid_high();
    apply_reset();
    @(negedge clk_clk);
    set_cmd(1'b1, 0, 1'b1, 32'd3, 4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_clk);
      set_cmd(1'b0, 0, 1'b0, '0, 0);
    end
    tests_run++;
    if (pto[0] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_high_pre got %b want 1", pto[0]);
    end
    #2;
    reset_reset = 1'b1;
    #1;
    tests_run++;
    if (pto !== '0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_pto got %b want 000", pto);
    end
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_clk);
      tests_run++;
      if ({pto, busy, done} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL post_reset k=%0d {pto,busy,done} got %b want 0", k, {pto, busy, done});
      end
    end
  endtask

  task automatic test_random();
    int c, ch, st, hp;
    logic v, dr, exp_rdy;
    logic [3:0] e, got;
    apply_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_used[i]     = 0;
      m_prev_dir[i] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_clk);
      c = cyc;
      for (int i = 0; i < N_CH; i++) begin
        e   = model_out(i, c);
        got = {pto[i], motor_dir[i], busy[i], done[i]};
        tests_run++;
        if (got !== e) begin
          tests_failed++;
          $display("[TB] FAIL random ch%0d n=%0d {pto,dir,busy,done} got %b want %b", i, n, got, e);
        end
      end
      ch = $urandom_range(0, N_CH);
      st = $urandom_range(0, 4);
      hp = $urandom_range(0, 3);
      dr = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 2) == 0);
      set_cmd(v, ch, dr, STEP_W'(st), hp);
      #1;
      exp_rdy = 1'b0;
      if (ch < N_CH) begin
        if (!m_used[ch]) exp_rdy = 1'b1;
        else if (c - m_start[ch] > busy_len(m_steps[ch], m_h[ch])) exp_rdy = 1'b1;
      end
      tests_run++;
      if (cmd.cmd_ready !== exp_rdy) begin
        tests_failed++;
        $display("[TB] FAIL random_ready ch%0d n=%0d got %b want %b", ch, n, cmd.cmd_ready, exp_rdy);
      end
      if (v && exp_rdy) begin
        e              = model_out(ch, c);
        m_prev_dir[ch] = e[2];
        m_used[ch]     = 1;
        m_start[ch]    = c;
        m_steps[ch]    = st;
        m_h[ch]        = (hp == 0) ? 1 : hp;
        m_dir[ch]      = dr;
      end
    end
    @(negedge clk_clk);
    set_cmd(1'b0, 0, 1'b0, '0, 0);
  endtask

  initial begin
    set_cmd(1'b0, 0, 1'b0, '0, 0);
    test_reset();
    test_basic();
    test_zero_steps();
    test_busy_reject();
    test_abort_high();
    test_abort_other();
    test_half_zero();
    test_max_steps();
    test_reset_mid_high();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
